fifo_rd_sched: RTL

FIFO_RD_SCHED -- requirements
Module: fifo_rd_sched

---
 rtl/fifo_rd_sched_pkg.sv | 21 ++
 rtl/fifo_rd_sched_rr_pick.sv | 38 +++
 rtl/fifo_rd_sched.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fifo_rd_sched_pkg.sv
// fifo_rd_sched_pkg -- shared definitions for the FIFO read-side blocks.
//   state_e      : read scheduler FSM states
//   *_DEF        : default NREQ / BLW / TMO values
//   idx_w()      : index width for an N-entry one-hot (never below 1)
package fifo_rd_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int NREQ_DEF = 4;
   localparam int BLW_DEF  = 3;
   localparam int TMO_DEF  = 15;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_rd_sched_rr_pick.sv
// rr_pick -- combinational round-robin selector.
//   req     in  NREQ  request levels
//   rr_ptr  in  IW    highest-priority index for this pick
//   win_oh  out NREQ  one-hot winner (zero when req is zero)
//   win_idx out IW    binary index of the winner
module rr_pick
   import fifo_rd_sched_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int IW   = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   rr_ptr,
   output logic [NREQ-1:0] win_oh,
   output logic [IW-1:0]   win_idx
);

   logic found;
   int   k;

   // Walk rr_ptr, rr_ptr+1, ... with wrap; the first requester seen wins.
   always_comb begin
      win_oh  = '0;
      win_idx = '0;
      found   = 1'b0;
      k       = 0;
      for (int i = 0; i < NREQ; i++) begin
         k = int'(rr_ptr) + i;
         if (k >= NREQ) k = k - NREQ;
         if (!found && req[k]) begin
            found     = 1'b1;
            win_oh[k] = 1'b1;
            win_idx   = IW'(k);
         end
      end
   end

endmodule

// File: rtl/fifo_rd_sched.sv
// fifo_rd_sched -- grants the FIFO read port to one consumer at a time for a
// committed burst of beats, pausing while the FIFO is empty and giving up
// after TMO consecutive empty cycles.
//   clck      in   clock (rising edge)
//   rst       in   synchronous reset, active low
//   req       in   per-consumer request levels
//   burst_len in   beats per grant (0 means 1)
//   empty     in   FIFO empty flag
//   inc       out  read-pointer advance
//   gnt       out  registered one-hot grant
//   vld       out  read data valid (inc delayed one cycle)
//   done      out  end-of-burst pulse
//   abort     out  end-of-burst-by-timeout pulse (with done)
//   busy      out  FSM not in IDLE
module fifo_rd_sched
   import fifo_rd_sched_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int BLW  = BLW_DEF,
   parameter int TMO  = TMO_DEF
) (
   input  logic            clck,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic [BLW-1:0]  burst_len,
   input  logic            empty,
   output logic            inc,
   output logic [NREQ-1:0] gnt,
   output logic            vld,
   output logic            done,
   output logic            abort,
   output logic            busy
);

   localparam int IW = idx_w(NREQ);
   localparam int TW = $clog2(TMO + 1);

   state_e          state_q, state_d;
   logic [NREQ-1:0] gnt_q;
   logic [IW-1:0]   win_q, rr_ptr_q;
   logic [BLW-1:0]  len_q, beat_q;
   logic [TW-1:0]   tmo_q;
   logic            abt_q, vld_q;
   logic [NREQ-1:0] win_oh;
   logic [IW-1:0]   win_idx;
   logic            last_beat, tmo_hit;

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
      .req     (req),
      .rr_ptr  (rr_ptr_q),
      .win_oh  (win_oh),
      .win_idx (win_idx)
   );

   assign last_beat = (beat_q == len_q - BLW'(1));
   // The counter still holds TMO-1 here; this empty cycle is the TMO-th.
   assign tmo_hit   = (tmo_q == TW'(TMO - 1));

   always_ff @(posedge clck) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|req) state_d = BURST;
         BURST: begin
            if (inc) begin
               if (last_beat) state_d = DONE;
            end else if (empty && tmo_hit) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // inc is also gated by rst so no pointer advance escapes during the
   // cycle in which reset is being applied.
   always_comb begin
      inc   = 1'b0;
      done  = 1'b0;
      abort = 1'b0;
      busy  = (state_q != IDLE);
      case (state_q)
         BURST: inc = ~empty & rst;
         DONE: begin
            done  = 1'b1;
            abort = abt_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clck) begin
      if (!rst) begin
         gnt_q    <= '0;
         win_q    <= '0;
         rr_ptr_q <= '0;
         len_q    <= '0;
         beat_q   <= '0;
         tmo_q    <= '0;
         abt_q    <= 1'b0;
         vld_q    <= 1'b0;
      end else begin
         vld_q <= inc;
         case (state_q)
            IDLE: if (|req) begin
               gnt_q  <= win_oh;
               win_q  <= win_idx;
               len_q  <= (burst_len == '0) ? BLW'(1) : burst_len;
               beat_q <= '0;
               tmo_q  <= '0;
               abt_q  <= 1'b0;
            end
            BURST: begin
               if (inc) begin
                  beat_q <= beat_q + BLW'(1);
                  tmo_q  <= '0;
               end else if (empty) begin
                  tmo_q  <= tmo_q + TW'(1);
               end
               if (state_d == DONE) begin
                  gnt_q <= '0;
                  abt_q <= ~inc;
               end
            end
            DONE: rr_ptr_q <= (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
            default: ;
         endcase
      end
   end

   assign gnt = gnt_q;
   assign vld = vld_q;

endmodule
